// File: rtl/gf128_pkg.sv
`default_nettype none
// ============================================================================
// gf128_pkg : shared constants, FSM state type and fold-count helper for the
//             GF(2^128) sequential reducer.            Revision 1.0
// ============================================================================
package gf128_pkg;

  localparam int           GF128_W  = 128;
  localparam int           GF128_PW = 256;
  localparam logic [127:0] GF128_R  = 128'h87;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int gf128_nf(input int chunk);
    return GF128_W / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf128_fold_slice.sv
`default_nettype none
// ============================================================================
// gf128_fold_slice : folds one CHUNK-wide window of the working register
//                    down by x^128 == R.                   Revision 1.0
// ============================================================================
module gf128_fold_slice
  import gf128_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [GF128_PW-1:0] r,
  input  logic [7:0]          top,
  output logic [GF128_PW-1:0] r_next
);

  localparam logic [7:0] SPAN = 8'(CHUNK - 1);

  logic [7:0]          base;
  logic [7:0]          shamt;
  logic [CHUNK-1:0]    win;
  logic [CHUNK+6:0]    rpoly;
  logic [CHUNK+6:0]    prod;
  logic [GF128_PW-1:0] mask;
  logic [GF128_PW-1:0] fold;

  // Window bits are carry-less multiplied by R as a whole, then placed at
  // degree (base-128); landed bits always sit below the window being cleared.
  always_comb begin
    base  = top - SPAN;
    shamt = base - 8'd128;
    win   = r[base +: CHUNK];
    rpoly = '0;
    rpoly[7:0] = GF128_R[7:0];
    prod  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (win[i]) prod = prod ^ (rpoly << i);
    end
    mask   = {{(GF128_PW-CHUNK){1'b0}}, {CHUNK{1'b1}}} << base;
    fold   = {{(GF128_PW-CHUNK-7){1'b0}}, prod} << shamt;
    r_next = (r & ~mask) ^ fold;
  end

endmodule
`default_nettype wire

// File: rtl/gf128_reduce_seq.sv
`default_nettype none
// ============================================================================
// gf128_reduce_seq : multi-cycle reduction of a 256-bit carry-less product
//                    modulo x^128 + x^7 + x^2 + x + 1.      Revision 1.0
// ============================================================================
module gf128_reduce_seq
  import gf128_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [GF128_PW-1:0] in_product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [GF128_W-1:0]  out_result,
  output logic                busy
);

  localparam bit CHUNK_OK = (CHUNK == 1) || (CHUNK == 2) || (CHUNK == 4) ||
                            (CHUNK == 8) || (CHUNK == 16) || (CHUNK == 32) ||
                            (CHUNK == 64);

  if (!CHUNK_OK) begin : g_bad_chunk
    $error("gf128_reduce_seq: CHUNK must be one of 1,2,4,8,16,32,64");
  end

  localparam int         NF   = gf128_nf(CHUNK);
  localparam logic [6:0] LAST = 7'(NF - 1);

  state_t              state;
  logic [GF128_PW-1:0] r;
  logic [GF128_PW-1:0] r_next;
  logic [6:0]          cnt;
  logic [7:0]          top;

  assign top = 8'd255 - 8'(32'(cnt) * CHUNK);

  gf128_fold_slice #(.CHUNK(CHUNK)) u_fold (
    .r      (r),
    .top    (top),
    .r_next (r_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= '0;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r        <= in_product;
            cnt      <= '0;
            state    <= FOLD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FOLD: begin
          r   <= r_next;
          cnt <= cnt + 7'd1;
          if (cnt == LAST) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= r_next[GF128_W-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf128_reduce_seq.sv
`default_nettype none
// ============================================================================
// tb_gf128_reduce_seq : scoreboard bench driving three reducer instances
//                       (CHUNK = 1, 8, 64) side by side.    Revision 1.0
// ============================================================================
module tb_gf128_reduce_seq;

  localparam int NCH   = 3;
  localparam int NRAND = 500;
  localparam int NRAW  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tfail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no event expected one within bound", name);
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Plain carry-less multiply as the upstream multiplier would produce.
  function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] acc = '0;
    for (int i = 0; i < 128; i++)
      if (b[i]) acc = acc ^ ({128'b0, a} << i);
    return acc;
  endfunction

  // Polynomial long division by P(x), keeping the remainder.
  function automatic logic [127:0] reduce_ref(input logic [255:0] p);
    logic [255:0] poly = (256'h1 << 128) | 256'h87;
    logic [255:0] rem  = p;
    for (int i = 255; i >= 128; i--)
      if (rem[i]) rem = rem ^ (poly << (i - 128));
    return rem[127:0];
  endfunction

  for (genvar ci = 0; ci < NCH; ci++) begin : g_h
    localparam int CH = (ci == 0) ? 1 : (ci == 1) ? 8 : 64;
    localparam int NF = 128 / CH;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_product;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_result;
    logic         busy;

    logic [127:0] exp_q[$];
    bit           bp_mode     = 1'b0;
    bit           ready_force = 1'b1;
    bit           done        = 1'b0;

    gf128_reduce_seq #(.CHUNK(CH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
    );

    always begin
      @(posedge clk);
      #2;
      out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    initial begin : monitor
      logic [127:0] e;
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tfail($sformatf("c%0d_spurious_output", CH));
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("c%0d_result", CH), 256'(out_result), 256'(e));
          end
        end
      end
    end

    task automatic send(input logic [255:0] p);
      int n = 0;
      in_valid   = 1'b1;
      in_product = p;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) tfail($sformatf("c%0d_accept_timeout", CH));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      if (exp_q.size() != 0) tfail($sformatf("c%0d_drain_timeout", CH));
      #1;
    endtask

    task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!out_valid) tfail($sformatf("c%0d_out_valid_timeout", CH));
    endtask

    task automatic check_reset_outputs(input string tag);
      chk($sformatf("c%0d_%s_in_ready", CH, tag), 256'(in_ready), 256'(1));
      chk($sformatf("c%0d_%s_out_valid", CH, tag), 256'(out_valid), 256'(0));
      chk($sformatf("c%0d_%s_busy", CH, tag), 256'(busy), 256'(0));
      chk($sformatf("c%0d_%s_out_result", CH, tag), 256'(out_result), 256'(0));
    endtask

    initial begin : driver
      logic [255:0] p;
      logic [127:0] e;
      int n;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_product = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // x^0 passes through; also measure accept-to-valid latency
      exp_q.push_back(128'h1);
      send(256'h1);
      n = 0;
      while (!out_valid && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("c%0d_latency", CH), 256'(n), 256'(NF));
      drain();

      exp_q.push_back(128'h87);
      send(256'h1 << 128);
      exp_q.push_back(128'hC0000000_00000000_00000000_00001067);
      send(256'h1 << 254);
      drain();

      // output stall with junk on the input side
      ready_force = 1'b0;
      p = {r128(), r128()};
      e = reduce_ref(p);
      exp_q.push_back(e);
      send(p);
      wait_out();
      repeat (20) begin
        @(posedge clk);
        #1;
        in_valid   = 1'($urandom_range(0, 1));
        in_product = {r128(), r128()};
        @(negedge clk);
        chk($sformatf("c%0d_stall_result", CH), 256'(out_result), 256'(e));
        chk($sformatf("c%0d_stall_in_ready", CH), 256'(in_ready), 256'(0));
        chk($sformatf("c%0d_stall_out_valid", CH), 256'(out_valid), 256'(1));
      end
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      ready_force = 1'b1;
      drain();

      // abort mid-fold: nothing may come out for the aborted product
      send({r128(), r128()});
      @(posedge clk);
      #1;
      chk($sformatf("c%0d_midfold_busy", CH), 256'(busy), 256'(1));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back(128'h87);
      send(256'h1 << 128);
      drain();

      // random multiplier outputs plus raw full-width words, with backpressure
      bp_mode = 1'b1;
      for (int i = 0; i < NRAND; i++) begin
        p = clmul(r128(), r128());
        exp_q.push_back(reduce_ref(p));
        send(p);
      end
      for (int i = 0; i < NRAW; i++) begin
        p = {r128(), r128()};
        exp_q.push_back(reduce_ref(p));
        send(p);
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin : summary
    int c = 0;
    while (!(g_h[0].done && g_h[1].done && g_h[2].done) && c < 95000) begin
      @(posedge clk);
      c++;
    end
    if (!(g_h[0].done && g_h[1].done && g_h[2].done)) tfail("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
